// File: rtl/soc_region_map.sv
// soc_region_map: programmable address-to-slave decoder.
// Holds NrRules base/length/ctrl rules behind a small config port with a
// sticky lock. It answers lookups through a one-stage registered
// valid/ready pipeline, and it keeps a saturating count of missed lookups.
module soc_region_map #(
    parameter int NrRules   = 10,
    parameter int AddrWidth = 64,
    parameter int NrSlaves  = 10,
    localparam int IdxW     = (NrSlaves > 1) ? $clog2(NrSlaves) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [4:0]           cfg_rule_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_ack_o,
    output logic                 cfg_err_o,
    input  logic                 cfg_lock_i,
    output logic                 locked_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [IdxW-1:0]      resp_idx_o,
    output logic                 resp_hit_o,
    output logic                 resp_multi_o,
    output logic [15:0]          miss_cnt_o
);

    logic [AddrWidth-1:0] base_q [NrRules];
    logic [AddrWidth-1:0] len_q  [NrRules];
    logic [IdxW-1:0]      idx_q  [NrRules];
    logic [NrRules-1:0]   en_q;
    logic                 locked_q;

    logic                 cfg_err_d;
    logic                 cfg_wr;
    logic [AddrWidth-1:0] cfg_rdata_d;
    logic [IdxW-1:0]      cfg_widx;

    logic [NrRules-1:0]   match_p0;
    logic                 hit_p0;
    logic                 multi_p0;
    logic [IdxW-1:0]      idx_p0;
    logic                 accept_p0;

    logic                 vld_p1;
    logic                 hit_p1;
    logic                 multi_p1;
    logic [IdxW-1:0]      idx_p1;
    logic [15:0]          miss_cnt_q;

    assign cfg_widx = cfg_wdata_i[IdxW:1];

    // Config decode: legality check, write enable and read mux.
    // A write is still legal in the cycle where the lock is raised.
    always_comb begin
        cfg_err_d   = 1'b0;
        cfg_rdata_d = '0;
        if (int'(cfg_rule_i) >= NrRules) cfg_err_d = 1'b1;
        if (cfg_field_i == 2'd3) cfg_err_d = 1'b1;
        if (cfg_we_i && locked_q) cfg_err_d = 1'b1;
        if (cfg_we_i && (cfg_field_i == 2'd2) && (int'(cfg_widx) >= NrSlaves)) cfg_err_d = 1'b1;
        if (!cfg_we_i && !cfg_err_d) begin
            for (int i = 0; i < NrRules; i++) begin
                if (cfg_rule_i == 5'(i)) begin
                    case (cfg_field_i)
                        2'd0:    cfg_rdata_d = base_q[i];
                        2'd1:    cfg_rdata_d = len_q[i];
                        2'd2:    cfg_rdata_d = AddrWidth'({idx_q[i], en_q[i]});
                        default: cfg_rdata_d = '0;
                    endcase
                end
            end
        end
        cfg_wr = cfg_req_i && cfg_we_i && !cfg_err_d;
    end

    // Rule storage. Lookups in the same cycle still see the old contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrRules; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                idx_q[i]  <= '0;
            end
            en_q <= '0;
        end else if (cfg_wr) begin
            for (int i = 0; i < NrRules; i++) begin
                if (cfg_rule_i == 5'(i)) begin
                    case (cfg_field_i)
                        2'd0: base_q[i] <= cfg_wdata_i;
                        2'd1: len_q[i]  <= cfg_wdata_i;
                        2'd2: begin
                            idx_q[i] <= cfg_widx;
                            en_q[i]  <= cfg_wdata_i[0];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Config response, one cycle after the strobe, plus the sticky lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_ack_o   <= 1'b0;
            cfg_err_o   <= 1'b0;
            cfg_rdata_o <= '0;
            locked_q    <= 1'b0;
        end else begin
            cfg_ack_o   <= cfg_req_i;
            cfg_err_o   <= cfg_req_i && cfg_err_d;
            cfg_rdata_o <= cfg_req_i ? cfg_rdata_d : '0;
            locked_q    <= locked_q || cfg_lock_i;
        end
    end

    assign locked_o = locked_q;

    // ---- stage p0: match all rules against the incoming address ----
    // The offset subtraction avoids forming base+length, so it cannot wrap.
    always_comb begin
        match_p0 = '0;
        hit_p0   = 1'b0;
        idx_p0   = '0;
        for (int i = 0; i < NrRules; i++) begin
            match_p0[i] = en_q[i] && (len_q[i] != '0) && (req_addr_i >= base_q[i])
                          && ((req_addr_i - base_q[i]) < len_q[i]);
        end
        for (int i = NrRules - 1; i >= 0; i--) begin
            if (match_p0[i]) begin
                hit_p0 = 1'b1;
                idx_p0 = idx_q[i];
            end
        end
        multi_p0 = (match_p0 & (match_p0 - NrRules'(1))) != '0;
    end

    assign req_ready_o = !vld_p1 || resp_ready_i;
    assign accept_p0   = req_valid_i && req_ready_o;

    // ---- stage p1: registered response, held while the consumer stalls ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1   <= 1'b0;
            hit_p1   <= 1'b0;
            multi_p1 <= 1'b0;
            idx_p1   <= '0;
        end else if (accept_p0) begin
            vld_p1   <= 1'b1;
            hit_p1   <= hit_p0;
            multi_p1 <= multi_p0;
            idx_p1   <= idx_p0;
        end else if (resp_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    // Saturating miss counter, bumped when a missing lookup is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_cnt_q <= '0;
        end else if (accept_p0 && !hit_p0 && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign resp_valid_o = vld_p1;
    assign resp_hit_o   = hit_p1;
    assign resp_multi_o = multi_p1;
    assign resp_idx_o   = idx_p1;
    assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_soc_region_map.sv
// Scoreboard bench for soc_region_map with directed vectors.
// The stimulus queues the expected responses. The monitor pops them on each
// handshake and compares.
module tb_soc_region_map;

    typedef struct packed {
        logic        hit;
        logic [3:0]  idx;
        logic        multi;
        logic [15:0] mc;
    } resp_t;

    typedef struct packed {
        logic        err;
        logic [63:0] rdata;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cfg_req_i, cfg_we_i, cfg_lock_i;
    logic [4:0]  cfg_rule_i;
    logic [1:0]  cfg_field_i;
    logic [63:0] cfg_wdata_i, cfg_rdata_o;
    logic        cfg_ack_o, cfg_err_o, locked_o;
    logic        req_valid_i, req_ready_o;
    logic [63:0] req_addr_i;
    logic        resp_valid_o, resp_ready_i, resp_hit_o, resp_multi_o;
    logic [3:0]  resp_idx_o;
    logic [15:0] miss_cnt_o;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_mc = 16'd0;
    resp_t rq[$];
    cfg_t  cq[$];

    always #5 clk = ~clk;

    soc_region_map dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_rule_i(cfg_rule_i),
        .cfg_field_i(cfg_field_i), .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o),
        .cfg_ack_o(cfg_ack_o), .cfg_err_o(cfg_err_o), .cfg_lock_i(cfg_lock_i),
        .locked_o(locked_o), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_idx_o(resp_idx_o), .resp_hit_o(resp_hit_o), .resp_multi_o(resp_multi_o),
        .miss_cnt_o(miss_cnt_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic hit, input logic [3:0] idx, input logic multi);
        if (!hit && exp_mc != 16'hFFFF) exp_mc = exp_mc + 16'd1;
        rq.push_back('{hit, idx, multi, exp_mc});
    endtask

    task automatic cfg_acc(input logic we, input logic [4:0] rule, input logic [1:0] field,
                           input logic [63:0] wd, input logic err, input logic [63:0] rd);
        cfg_req_i   = 1'b1;
        cfg_we_i    = we;
        cfg_rule_i  = rule;
        cfg_field_i = field;
        cfg_wdata_i = wd;
        cq.push_back('{err, rd});
        tick();
        cfg_req_i = 1'b0;
        cfg_we_i  = 1'b0;
    endtask

    task automatic lookup(input logic [63:0] a, input logic hit, input logic [3:0] idx,
                          input logic multi);
        int n;
        push_exp(hit, idx, multi);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        n = 0;
        while (!req_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            failures++;
            $display("FAIL lookup_timeout addr=0x%0h", a);
        end
        tick();
        req_valid_i = 1'b0;
    endtask

    // Monitor: compare every presented response and every config ack.
    initial begin
        resp_t e;
        cfg_t  c;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (resp_valid_o && resp_ready_i) begin
                    if (rq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL resp_unexpected actual=response required=none");
                    end else begin
                        e = rq.pop_front();
                        chk("resp_hit", resp_hit_o, e.hit);
                        chk("resp_idx", resp_idx_o, e.idx);
                        chk("resp_multi", resp_multi_o, e.multi);
                        chk("miss_cnt", miss_cnt_o, e.mc);
                    end
                end
                if (cfg_ack_o) begin
                    if (cq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL cfg_ack_unexpected actual=ack required=none");
                    end else begin
                        c = cq.pop_front();
                        chk("cfg_err", cfg_err_o, c.err);
                        chk("cfg_rdata", cfg_rdata_o, c.rdata);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst_ni = 1'b0;
        cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_lock_i = 1'b0;
        cfg_rule_i = '0; cfg_field_i = '0; cfg_wdata_i = '0;
        req_valid_i = 1'b0; req_addr_i = '0; resp_ready_i = 1'b1;
        tick(); tick();
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_cfg_ack", cfg_ack_o, 0);
        chk("rst_cfg_err", cfg_err_o, 0);
        chk("rst_cfg_rdata", cfg_rdata_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_miss_cnt", miss_cnt_o, 0);
        chk("rst_resp_idx", {resp_idx_o, resp_hit_o, resp_multi_o}, 0);
        rst_ni = 1'b1;
        tick();

        // Single rule, hit at the last byte and miss one past it.
        cfg_acc(1, 0, 0, 64'h8000_0000, 0, 0);
        cfg_acc(1, 0, 1, 64'h4000_0000, 0, 0);
        cfg_acc(1, 0, 2, 64'h1, 0, 0);
        lookup(64'hBFFF_FFFF, 1, 0, 0);
        lookup(64'hC000_0000, 0, 0, 0);

        // Rule at the top of the address space must not wrap to zero.
        cfg_acc(1, 4, 0, 64'hFFFF_FFFF_FFFF_F000, 0, 0);
        cfg_acc(1, 4, 1, 64'h2000, 0, 0);
        cfg_acc(1, 4, 2, 64'hB, 0, 0);
        lookup(64'hFFFF_FFFF_FFFF_FFFF, 1, 5, 0);
        lookup(64'h0, 0, 0, 0);

        // Overlap: the lower rule number wins.
        cfg_acc(1, 1, 0, 64'h0, 0, 0);
        cfg_acc(1, 1, 1, 64'h1000, 0, 0);
        cfg_acc(1, 1, 2, 64'h13, 0, 0);
        cfg_acc(1, 3, 0, 64'h0, 0, 0);
        cfg_acc(1, 3, 1, 64'h1_0000, 0, 0);
        cfg_acc(1, 3, 2, 64'h11, 0, 0);
        lookup(64'h800, 1, 9, 1);
        lookup(64'h2000, 1, 8, 0);

        // Readback and illegal accesses.
        cfg_acc(0, 1, 2, 64'h0, 0, 64'h13);
        cfg_acc(0, 3, 1, 64'h0, 0, 64'h1_0000);
        cfg_acc(1, 2, 2, 64'h15, 1, 0);
        cfg_acc(0, 2, 2, 64'h0, 0, 0);
        cfg_acc(0, 1, 3, 64'h0, 1, 0);
        cfg_acc(1, 10, 0, 64'h1234, 1, 0);
        cfg_acc(0, 10, 0, 64'h0, 1, 0);

        // A write in the lookup's acceptance cycle is seen only by later lookups.
        cfg_acc(1, 5, 0, 64'h2_0000_0000, 0, 0);
        cfg_acc(1, 5, 1, 64'h100, 0, 0);
        cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_rule_i = 5; cfg_field_i = 2; cfg_wdata_i = 64'h5;
        cq.push_back('{1'b0, 64'h0});
        push_exp(0, 0, 0);
        req_valid_i = 1'b1; req_addr_i = 64'h2_0000_0000;
        tick();
        cfg_req_i = 1'b0; cfg_we_i = 1'b0; req_valid_i = 1'b0;
        lookup(64'h2_0000_0000, 1, 2, 0);

        // A lock raised together with a write still lets that write through.
        cfg_lock_i = 1'b1;
        cfg_acc(1, 6, 0, 64'h7000, 0, 0);
        cfg_lock_i = 1'b0;
        chk("locked_set", locked_o, 1);
        cfg_acc(1, 2, 0, 64'hABCD, 1, 0);
        cfg_acc(0, 2, 0, 64'h0, 0, 0);
        cfg_acc(0, 6, 0, 64'h0, 0, 64'h7000);
        tick();
        chk("locked_sticky", locked_o, 1);

        // Back-pressure: responses are held and come out in order.
        resp_ready_i = 1'b0;
        push_exp(1, 0, 0);
        req_valid_i = 1'b1; req_addr_i = 64'hBFFF_FFF0;
        tick();
        push_exp(1, 9, 1);
        req_addr_i = 64'h800;
        for (int k = 0; k < 3; k++) begin
            chk("stall_req_ready", req_ready_o, 0);
            chk("stall_resp_valid", resp_valid_o, 1);
            chk("stall_resp_idx", {resp_idx_o, resp_hit_o, resp_multi_o}, 6'b0000_1_0);
            tick();
        end
        resp_ready_i = 1'b1;
        tick();
        push_exp(0, 0, 0);
        req_addr_i = 64'hC000_0000;
        tick();
        req_valid_i = 1'b0;
        tick(); tick();

        // Reset with a response pending: it must vanish and rules must clear.
        resp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 64'h800;
        tick();
        req_valid_i = 1'b0;
        rst_ni = 1'b0;
        rq.delete();
        #1;
        chk("midrst_resp_valid", resp_valid_o, 0);
        chk("midrst_miss_cnt", miss_cnt_o, 0);
        chk("midrst_locked", locked_o, 0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        chk("post_rst_valid", resp_valid_o, 0);
        tick();
        chk("post_rst_valid2", resp_valid_o, 0);
        resp_ready_i = 1'b1;
        exp_mc = 16'd0;
        lookup(64'hBFFF_FFFF, 0, 0, 0);

        // Stream misses until the counter saturates.
        req_valid_i = 1'b1;
        req_addr_i  = 64'h123;
        for (int k = 0; k < 65535; k++) begin
            push_exp(0, 0, 0);
            tick();
        end
        req_valid_i = 1'b0;
        tick(); tick();
        chk("miss_cnt_sat", miss_cnt_o, 16'hFFFF);

        n = 0;
        while ((rq.size() != 0 || cq.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        if (rq.size() != 0 || cq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout resp_left=%0d cfg_left=%0d", rq.size(), cq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_region_map.md
SOC_REGION_MAP -- requirements
Module: soc_region_map

Interface
REQ-001 SHALL have parameter NrRules, default 10, number of programmable address rules (1..32).
REQ-002 SHALL have parameter AddrWidth, default 64, width of address, base and length fields.
REQ-003 SHALL have parameter NrSlaves, default 10, number of target slave indices; IdxW = max(1, $clog2(NrSlaves)).
REQ-004 SHALL have ports clk_i input 1 clock, and rst_ni input 1 reset; the reset is asynchronous and active-low.
REQ-005 SHALL have port cfg_req_i input 1 config access strobe (single cycle).
REQ-006 SHALL have ports cfg_we_i input 1 (write=1), cfg_rule_i input 5 (rule index), and cfg_field_i input 2 (0=base, 1=length, 2=ctrl).
REQ-007 SHALL have ports cfg_wdata_i input AddrWidth, cfg_rdata_o output AddrWidth, cfg_ack_o output 1, and cfg_err_o output 1.
REQ-008 SHALL have port cfg_lock_i input 1, which sets the sticky configuration lock.
REQ-009 SHALL have port locked_o output 1, the current lock state.
REQ-010 SHALL have ports req_valid_i input 1, req_ready_o output 1, and req_addr_i input AddrWidth, forming the lookup request handshake.
REQ-011 SHALL have ports resp_valid_o output 1, resp_ready_i input 1, resp_idx_o output IdxW, resp_hit_o output 1, and resp_multi_o output 1, forming the lookup response handshake.
REQ-012 SHALL have port miss_cnt_o output 16, a saturating count of missed lookups.

Function
REQ-013 SHALL hold per rule: base[AddrWidth], length[AddrWidth], and ctrl{enable, idx[IdxW]}; the ctrl field maps to wdata bits [IdxW:1]=idx and bit0=enable.
REQ-014 A rule SHALL match iff enable=1, length!=0, addr>=base, and (addr-base)<length; the comparison SHALL be overflow-free at base+length wrap.
REQ-015 On overlap, the lowest-numbered matching rule SHALL win, and resp_multi_o SHALL be 1 when two or more rules match.
REQ-016 On no match: resp_hit_o=0, resp_idx_o=0, and miss_cnt_o SHALL increment, saturating at 16'hFFFF.
REQ-017 Lookup SHALL be a registered stage: request accepted on req_valid_i&&req_ready_o; response valid on the next cycle.
REQ-018 req_ready_o SHALL equal !resp_valid_o || resp_ready_i, giving full throughput of 1 lookup/cycle under continuous ready.
REQ-019 resp_* outputs SHALL stay stable while resp_valid_o=1 and resp_ready_i=0.
REQ-020 A lookup SHALL use the rule contents as they were in its acceptance cycle; a config write in that same cycle SHALL be visible only to later lookups.
REQ-021 A config access SHALL give cfg_ack_o=1 for exactly one cycle, the cycle after cfg_req_i; cfg_rdata_o SHALL be valid with that ack (0 on writes and errors).
REQ-022 cfg_err_o SHALL pulse with ack, with no state change, when: cfg_rule_i>=NrRules, cfg_field_i==3, a write occurs with locked_o=1, or a ctrl idx is >=NrSlaves.
REQ-023 Reads SHALL be permitted while locked.
REQ-024 cfg_lock_i=1 SHALL set locked_o on the next cycle; locked_o SHALL clear only on reset.
REQ-025 When cfg_lock_i and a write occur in the same cycle, the write SHALL be applied; locking takes effect for subsequent cycles.
REQ-026 cfg_req_i asserted in the ack cycle SHALL be accepted as a new access (back-to-back at 1/cycle).

Reset
REQ-027 On rst_ni=0, asynchronously: all base/length/ctrl=0 (all rules disabled), locked_o=0, resp_valid_o=0, resp_idx_o=0, resp_hit_o=0, resp_multi_o=0, cfg_ack_o=0, cfg_err_o=0, cfg_rdata_o=0, and miss_cnt_o=0.
REQ-028 Reset asserted mid-lookup SHALL drop the pending response, which is never presented after reset release.
REQ-029 The first lookup accepted after reset release SHALL miss.

Verification
REQ-030 Program rule0 base=0x8000_0000, len=0x4000_0000, idx=0, en=1; look up 0xBFFF_FFFF -> hit=1, idx=0; look up 0xC000_0000 -> hit=0, miss_cnt_o=1.
REQ-031 Program rule1 base=0x0, len=0x1000, idx=9 and rule3 base=0x0, len=0x1_0000, idx=8; look up 0x800 -> idx=9, multi=1; look up 0x2000 -> idx=8, multi=0.
REQ-032 Set cfg_lock_i, then write rule2 -> cfg_err_o=1, ack=1; read back rule2 base -> 0, err=0.
REQ-033 Hold resp_ready_i=0 for 3 cycles with req_valid_i=1 -> req_ready_o=0 and resp_* stable; release ready -> one response per cycle, in order.
REQ-034 Rule with base=0xFFFF_FFFF_FFFF_F000, len=0x2000: addr 0xFFFF_FFFF_FFFF_FFFF -> hit; addr 0x0 -> miss (no wrap).
REQ-035 Write cfg_rule_i=NrRules -> err=1; drive 65536 misses -> miss_cnt_o saturates at 0xFFFF.
